// File: rtl/bkm_step_scoreboard.sv
// bkm_step_scoreboard: gathers run statistics from the bkm_step checker
// (sample/warning/error counts, max |delta|, first error) and streams a
// fixed 14-word report over a valid/ready interface on request.
module bkm_step_scoreboard #(
  parameter int WC    = 16,
  parameter int WD    = 64,
  parameter int LOG2N = 6,
  parameter int WCNT  = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic [LOG2N-1:0] tb_n,
  input  logic [3:0]       war,
  input  logic [3:0]       err,
  input  logic [WC-1:0]    delta_u,
  input  logic [WC-1:0]    delta_v,
  input  logic [WD-1:0]    delta_X,
  input  logic [WD-1:0]    delta_Y,
  input  logic             dump_req,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [3:0]       rpt_idx,
  output logic [WD-1:0]    rpt_data,
  output logic             rpt_last,
  output logic             busy,
  output logic             pass,
  output logic             first_err_vld
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DUMP = 1'b1} state_e;

  localparam logic [3:0] LAST_IDX = 4'd13;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [WCNT-1:0] sat_inc(input logic [WCNT-1:0] cnt,
                                               input logic            inc);
    return (inc && (cnt != {WCNT{1'b1}})) ? (cnt + {{(WCNT-1){1'b0}}, 1'b1}) : cnt;
  endfunction

  // Unsigned magnitude of a control-path delta; -2^(WC-1) maps to 2^(WC-1).
  function automatic logic [WC-1:0] abs_c(input logic [WC-1:0] d);
    return d[WC-1] ? (~d + {{(WC-1){1'b0}}, 1'b1}) : d;
  endfunction

  // Unsigned magnitude of a data-path delta; -2^(WD-1) maps to 2^(WD-1).
  function automatic logic [WD-1:0] abs_d(input logic [WD-1:0] d);
    return d[WD-1] ? (~d + {{(WD-1){1'b0}}, 1'b1}) : d;
  endfunction

  state_e                state_q, state_d;
  logic [WCNT-1:0]       sample_cnt_q, sample_cnt_d;
  logic [3:0][WCNT-1:0]  war_cnt_q, war_cnt_d;
  logic [3:0][WCNT-1:0]  err_cnt_q, err_cnt_d;
  logic [WC-1:0]         max_u_q, max_u_d, max_v_q, max_v_d;
  logic [WD-1:0]         max_x_q, max_x_d, max_y_q, max_y_d;
  logic                  first_err_vld_q, first_err_vld_d;
  logic [WCNT-1:0]       first_err_sample_q, first_err_sample_d;
  logic [LOG2N-1:0]      first_err_n_q, first_err_n_d;
  logic [3:0]            first_err_mask_q, first_err_mask_d;
  logic                  rpt_valid_q, rpt_valid_d;
  logic [3:0]            rpt_idx_q, rpt_idx_d;
  logic [WD-1:0]         rpt_data_q, rpt_data_d;
  logic                  rpt_last_q, rpt_last_d;
  logic                  busy_q, busy_d;
  logic                  pass_q, pass_d;

  logic                  accept_s;
  logic                  fe_take_s;
  logic [WC-1:0]         abs_u_s, abs_v_s;
  logic [WD-1:0]         abs_x_s, abs_y_s;
  logic [WD-1:0]         rpt_word_s;

  // Next statistics: accumulate samples accepted in IDLE, clear on srst.
  always_comb begin
    accept_s  = (state_q == ST_IDLE) && enable;
    abs_u_s   = abs_c(delta_u);
    abs_v_s   = abs_c(delta_v);
    abs_x_s   = abs_d(delta_X);
    abs_y_s   = abs_d(delta_Y);
    fe_take_s = accept_s && !first_err_vld_q && (err != 4'b0000);
    if (srst) begin
      sample_cnt_d = {WCNT{1'b0}};
      for (int i = 0; i < 4; i++) begin
        war_cnt_d[i] = {WCNT{1'b0}};
        err_cnt_d[i] = {WCNT{1'b0}};
      end
      max_u_d            = {WC{1'b0}};
      max_v_d            = {WC{1'b0}};
      max_x_d            = {WD{1'b0}};
      max_y_d            = {WD{1'b0}};
      first_err_vld_d    = 1'b0;
      first_err_sample_d = {WCNT{1'b0}};
      first_err_n_d      = {LOG2N{1'b0}};
      first_err_mask_d   = 4'b0000;
    end else begin
      sample_cnt_d = accept_s ? sat_inc(sample_cnt_q, 1'b1) : sample_cnt_q;
      for (int i = 0; i < 4; i++) begin
        war_cnt_d[i] = accept_s ? sat_inc(war_cnt_q[i], war[i]) : war_cnt_q[i];
        err_cnt_d[i] = accept_s ? sat_inc(err_cnt_q[i], err[i]) : err_cnt_q[i];
      end
      max_u_d            = (accept_s && (abs_u_s > max_u_q)) ? abs_u_s : max_u_q;
      max_v_d            = (accept_s && (abs_v_s > max_v_q)) ? abs_v_s : max_v_q;
      max_x_d            = (accept_s && (abs_x_s > max_x_q)) ? abs_x_s : max_x_q;
      max_y_d            = (accept_s && (abs_y_s > max_y_q)) ? abs_y_s : max_y_q;
      first_err_vld_d    = first_err_vld_q || fe_take_s;
      first_err_sample_d = fe_take_s ? sample_cnt_q : first_err_sample_q;
      first_err_n_d      = fe_take_s ? tb_n : first_err_n_q;
      first_err_mask_d   = fe_take_s ? err : first_err_mask_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sample_cnt_q       <= {WCNT{1'b0}};
      war_cnt_q          <= {(4*WCNT){1'b0}};
      err_cnt_q          <= {(4*WCNT){1'b0}};
      max_u_q            <= {WC{1'b0}};
      max_v_q            <= {WC{1'b0}};
      max_x_q            <= {WD{1'b0}};
      max_y_q            <= {WD{1'b0}};
      first_err_vld_q    <= 1'b0;
      first_err_sample_q <= {WCNT{1'b0}};
      first_err_n_q      <= {LOG2N{1'b0}};
      first_err_mask_q   <= 4'b0000;
    end else begin
      sample_cnt_q       <= sample_cnt_d;
      war_cnt_q          <= war_cnt_d;
      err_cnt_q          <= err_cnt_d;
      max_u_q            <= max_u_d;
      max_v_q            <= max_v_d;
      max_x_q            <= max_x_d;
      max_y_q            <= max_y_d;
      first_err_vld_q    <= first_err_vld_d;
      first_err_sample_q <= first_err_sample_d;
      first_err_n_q      <= first_err_n_d;
      first_err_mask_q   <= first_err_mask_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start on dump_req, finish when word 13 is accepted.
  always_comb begin
    state_d = ST_IDLE;
    if (srst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = dump_req ? ST_DUMP : ST_IDLE;
        ST_DUMP: state_d = (rpt_ready && (rpt_idx_q == LAST_IDX)) ? ST_IDLE : ST_DUMP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Report word selection from next-cycle statistics, so a sample accepted
  // alongside dump_req appears in the report.
  always_comb begin
    rpt_word_s = {WD{1'b0}};
    case (rpt_idx_d)
      4'd0:    rpt_word_s = WD'(sample_cnt_d);
      4'd1:    rpt_word_s = WD'(war_cnt_d[0]);
      4'd2:    rpt_word_s = WD'(war_cnt_d[1]);
      4'd3:    rpt_word_s = WD'(war_cnt_d[2]);
      4'd4:    rpt_word_s = WD'(war_cnt_d[3]);
      4'd5:    rpt_word_s = WD'(err_cnt_d[0]);
      4'd6:    rpt_word_s = WD'(err_cnt_d[1]);
      4'd7:    rpt_word_s = WD'(err_cnt_d[2]);
      4'd8:    rpt_word_s = WD'(err_cnt_d[3]);
      4'd9:    rpt_word_s = WD'(max_u_d);
      4'd10:   rpt_word_s = WD'(max_v_d);
      4'd11:   rpt_word_s = max_x_d;
      4'd12:   rpt_word_s = max_y_d;
      4'd13:   rpt_word_s = first_err_vld_d ?
                            WD'({first_err_mask_d, first_err_n_d, first_err_sample_d}) :
                            {WD{1'b0}};
      default: rpt_word_s = {WD{1'b0}};
    endcase
  end

  // FSM outputs: index advances on each accepted word and holds on stall.
  always_comb begin
    if (state_d == ST_DUMP) begin
      if ((state_q == ST_DUMP) && rpt_ready) begin
        rpt_idx_d = rpt_idx_q + 4'd1;
      end else if (state_q == ST_DUMP) begin
        rpt_idx_d = rpt_idx_q;
      end else begin
        rpt_idx_d = 4'd0;
      end
    end else begin
      rpt_idx_d = 4'd0;
    end
    rpt_valid_d = (state_d == ST_DUMP);
    busy_d      = (state_d == ST_DUMP);
    rpt_last_d  = rpt_valid_d && (rpt_idx_d == LAST_IDX);
    rpt_data_d  = rpt_valid_d ? rpt_word_s : {WD{1'b0}};
    pass_d      = (sample_cnt_d != {WCNT{1'b0}}) && (err_cnt_d == {(4*WCNT){1'b0}});
  end

  // Output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rpt_valid_q <= 1'b0;
      rpt_idx_q   <= 4'd0;
      rpt_data_q  <= {WD{1'b0}};
      rpt_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      rpt_valid_q <= rpt_valid_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_data_q  <= rpt_data_d;
      rpt_last_q  <= rpt_last_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
    end
  end

  assign rpt_valid     = rpt_valid_q;
  assign rpt_idx       = rpt_idx_q;
  assign rpt_data      = rpt_data_q;
  assign rpt_last      = rpt_last_q;
  assign busy          = busy_q;
  assign pass          = pass_q;
  assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_bkm_step_scoreboard.sv
// Testbench for bkm_step_scoreboard: directed scenarios plus a randomized
// phase, all checked every cycle against a behavioural statistics model.
module tb_bkm_step_scoreboard;
  localparam int WC = 16, WD = 64, LOG2N = 6, WCNT = 32;
  localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             arst, srst, enable, dump_req, rpt_ready;
  logic [LOG2N-1:0] tb_n;
  logic [3:0]       war, err;
  logic [WC-1:0]    delta_u, delta_v;
  logic [WD-1:0]    delta_X, delta_Y;
  logic             rpt_valid, rpt_last, busy, pass, first_err_vld;
  logic [3:0]       rpt_idx;
  logic [WD-1:0]    rpt_data;

  always #5 clk = ~clk;

  bkm_step_scoreboard #(.WC(WC), .WD(WD), .LOG2N(LOG2N), .WCNT(WCNT)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .tb_n(tb_n),
    .war(war), .err(err), .delta_u(delta_u), .delta_v(delta_v),
    .delta_X(delta_X), .delta_Y(delta_Y), .dump_req(dump_req),
    .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_idx(rpt_idx),
    .rpt_data(rpt_data), .rpt_last(rpt_last), .busy(busy), .pass(pass),
    .first_err_vld(first_err_vld)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the run statistics and the report stream.
  longint unsigned m_sample;
  longint unsigned m_war[4];
  longint unsigned m_err[4];
  logic [63:0]     m_max[4];
  bit              m_fe_vld;
  logic [3:0]      m_fe_mask;
  logic [5:0]      m_fe_n;
  longint unsigned m_fe_sample;
  bit              m_dump;
  int              m_idx;

  logic [63:0]     rx[14];
  int              rx_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sample = 0;
    for (int i = 0; i < 4; i++) begin
      m_war[i] = 0; m_err[i] = 0; m_max[i] = 64'd0;
    end
    m_fe_vld = 0; m_fe_mask = 4'd0; m_fe_n = 6'd0; m_fe_sample = 0;
    m_dump = 0; m_idx = 0;
  endtask

  function automatic logic [63:0] mag16(input logic [15:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    return 64'(v);
  endfunction

  function automatic logic [63:0] mag64(input logic [63:0] d);
    logic signed [64:0] t;
    t = $signed({d[63], d});
    if (t < 0) t = -t;
    return t[63:0];
  endfunction

  function automatic logic [63:0] exp_word(input int i);
    if (i == 0) return m_sample;
    if (i >= 1 && i <= 4) return m_war[i-1];
    if (i >= 5 && i <= 8) return m_err[i-5];
    if (i >= 9 && i <= 12) return m_max[i-9];
    if (!m_fe_vld) return 64'd0;
    return (64'(m_fe_mask) << 38) | (64'(m_fe_n) << 32) | 64'(m_fe_sample);
  endfunction

  function automatic bit exp_pass();
    return (m_sample != 0) && (m_err[0] == 0) && (m_err[1] == 0) &&
           (m_err[2] == 0) && (m_err[3] == 0);
  endfunction

  task automatic model_step();
    logic [63:0] mags[4];
    if (srst) begin
      model_clear();
    end else if (m_dump) begin
      if (rpt_ready) begin
        if (m_idx == 13) m_dump = 0;
        else m_idx++;
      end
    end else begin
      if (enable) begin
        if (!m_fe_vld && err != 4'd0) begin
          m_fe_vld = 1; m_fe_sample = m_sample; m_fe_n = tb_n; m_fe_mask = err;
        end
        if (m_sample < CNT_MAX) m_sample++;
        mags[0] = mag16(delta_u); mags[1] = mag16(delta_v);
        mags[2] = mag64(delta_X); mags[3] = mag64(delta_Y);
        for (int i = 0; i < 4; i++) begin
          if (war[i] && m_war[i] < CNT_MAX) m_war[i]++;
          if (err[i] && m_err[i] < CNT_MAX) m_err[i]++;
          if (mags[i] > m_max[i]) m_max[i] = mags[i];
        end
      end
      if (dump_req) begin
        m_dump = 1; m_idx = 0;
      end
    end
  endtask

  task automatic compare();
    chk("rpt_valid", rpt_valid, m_dump);
    chk("busy", busy, m_dump);
    chk("pass", pass, exp_pass());
    chk("first_err_vld", first_err_vld, m_fe_vld);
    if (m_dump) begin
      chk("rpt_idx", rpt_idx, m_idx);
      chk($sformatf("rpt_data[%0d]", m_idx), rpt_data, exp_word(m_idx));
      chk("rpt_last", rpt_last, m_idx == 13);
    end else begin
      chk("rpt_last_idle", rpt_last, 1'b0);
    end
  endtask

  // One clock: record accepted words, advance model with DUT, then check.
  task automatic tick();
    if (rpt_valid && rpt_ready) begin
      rx[rpt_idx] = rpt_data;
      rx_cnt++;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic sample(input logic [3:0] w, input logic [3:0] e, input logic [5:0] n,
                        input logic [15:0] du, input logic [15:0] dv,
                        input logic [63:0] dx, input logic [63:0] dy);
    enable = 1'b1; war = w; err = e; tb_n = n;
    delta_u = du; delta_v = dv; delta_X = dx; delta_Y = dy;
    tick();
    enable = 1'b0; war = 4'd0; err = 4'd0;
  endtask

  task automatic srst_pulse();
    srst = 1'b1; tick(); srst = 1'b0;
  endtask

  task automatic clear_rx();
    for (int i = 0; i < 14; i++) rx[i] = 64'd0;
    rx_cnt = 0;
  endtask

  task automatic run_dump(output int cyc);
    clear_rx();
    rpt_ready = 1'b1;
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 64) begin tick(); cyc++; end
    chk("dump_terminates", busy, 1'b0);
  endtask

  initial begin
    int cyc;
    logic [3:0][31:0] fv;
    arst = 1'b1; srst = 1'b0; enable = 1'b0; dump_req = 1'b0; rpt_ready = 1'b0;
    tb_n = 6'd0; war = 4'd0; err = 4'd0;
    delta_u = 16'd0; delta_v = 16'd0; delta_X = 64'd0; delta_Y = 64'd0;
    model_clear(); clear_rx();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", rpt_valid, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_idx", rpt_idx, 4'd0);     chk("rst_data", rpt_data, 64'd0);
    chk("rst_pass", pass, 1'b0);       chk("rst_fev", first_err_vld, 1'b0);
    arst = 1'b0;
    tick();

    // 100 clean samples, then a full-speed dump
    for (int i = 0; i < 100; i++) sample(4'd0, 4'd0, 6'd0, 16'd0, 16'd0, 64'd0, 64'd0);
    chk("t1_pass", pass, 1'b1);
    run_dump(cyc);
    chk("t1_cycles", cyc, 14); chk("t1_words", rx_cnt, 14);
    chk("t1_word0", rx[0], 64'd100);
    for (int i = 1; i < 14; i++) chk($sformatf("t1_word%0d", i), rx[i], 64'd0);

    // First-error capture
    srst_pulse();
    for (int i = 0; i < 10; i++)
      sample(4'($urandom), (i == 5) ? 4'b0100 : ((i == 8) ? 4'b0001 : 4'b0000),
             (i == 5) ? 6'd17 : 6'($urandom), rnd16(), rnd16(), rnd64(), rnd64());
    chk("t2_fev", first_err_vld, 1'b1); chk("t2_pass", pass, 1'b0);
    run_dump(cyc);
    chk("t2_word0", rx[0], 64'd10); chk("t2_err_u", rx[5], 64'd1);
    chk("t2_err_v", rx[6], 64'd0);  chk("t2_err_X", rx[7], 64'd1);
    chk("t2_err_Y", rx[8], 64'd0);
    chk("t2_word13", rx[13], 64'h0000_0111_0000_0005);

    // Most-negative control delta
    srst_pulse();
    sample(4'd0, 4'd0, 6'd0, 16'h8000, 16'd0, 64'd0, 64'd0);
    sample(4'd0, 4'd0, 6'd0, 16'h7FFF, 16'd0, 64'd0, 64'd0);
    sample(4'd0, 4'd0, 6'd0, 16'hFFFF, 16'd0, 64'd0, 64'd0);
    run_dump(cyc);
    chk("t3_max_u", rx[9], 64'd32768);

    // Counter saturation
    srst_pulse();
    fv = {32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0};
    force dut.war_cnt_q = fv;
    #1;
    release dut.war_cnt_q;
    m_war[1] = 64'h0000_0000_FFFF_FFFE;
    for (int i = 0; i < 3; i++) sample(4'b0010, 4'd0, 6'd0, 16'd0, 16'd0, 64'd0, 64'd0);
    run_dump(cyc);
    chk("t4_war_v_sat", rx[2], 64'h0000_0000_FFFF_FFFF);

    // Back-pressure, samples during dump, repeated dump_req
    srst_pulse();
    for (int i = 0; i < 20; i++)
      sample(4'($urandom), 4'd0, 6'($urandom), rnd16(), rnd16(), rnd64(), rnd64());
    clear_rx();
    rpt_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    tick();
    rpt_ready = 1'b0; enable = 1'b1; err = 4'hF; war = 4'hF;
    tick(); chk("t5_stall_idx_a", rpt_idx, 4'd1);
    tick(); chk("t5_stall_idx_b", rpt_idx, 4'd1);
    rpt_ready = 1'b1; dump_req = 1'b1; tick();
    dump_req = 1'b0; enable = 1'b0; err = 4'd0; war = 4'd0;
    cyc = 0;
    while (busy && cyc < 64) begin tick(); cyc++; end
    chk("t5_done", busy, 1'b0);
    chk("t5_words", rx_cnt, 14); chk("t5_word0", rx[0], 64'd20);
    for (int i = 5; i < 9; i++) chk($sformatf("t5_err%0d", i), rx[i], 64'd0);
    tick(); chk("t5_no_redump", busy, 1'b0);

    // srst in the middle of a dump
    sample(4'b0001, 4'b1000, 6'd3, rnd16(), rnd16(), rnd64(), rnd64());
    rpt_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    cyc = 0;
    while (rpt_idx != 4'd6 && cyc < 20) begin tick(); cyc++; end
    chk("t6_reach_idx6", rpt_idx, 4'd6);
    srst = 1'b1; tick(); srst = 1'b0;
    chk("t6_valid", rpt_valid, 1'b0); chk("t6_busy", busy, 1'b0);
    chk("t6_fev", first_err_vld, 1'b0); chk("t6_pass", pass, 1'b0);
    run_dump(cyc);
    for (int i = 0; i < 14; i++) chk($sformatf("t6_word%0d", i), rx[i], 64'd0);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      enable    = ($urandom_range(0, 3) != 0);
      war       = 4'($urandom);
      err       = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
      tb_n      = 6'($urandom);
      delta_u   = rnd16(); delta_v = rnd16();
      delta_X   = rnd64(); delta_Y = rnd64();
      dump_req  = ($urandom_range(0, 19) == 0);
      rpt_ready = ($urandom_range(0, 3) != 0);
      srst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    enable = 1'b0; dump_req = 1'b0; srst = 1'b0; rpt_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 64) begin tick(); cyc++; end
    chk("final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
